// File: rtl/sensor_scan_ctl.sv
`default_nettype none
// ============================================================================
// sensor_scan_ctl : round-robin sensor sampler with offset correction,
//                   range check, ack timeout and per-channel sticky errors.
// Revision: 1.0
// ============================================================================
module sensor_scan_ctl #(
  parameter int DataBits      = 10,
  parameter int Channels      = 4,
  parameter int ChBits        = 2,
  parameter int UpBound       = 1000,
  parameter int DownBound     = 16,
  parameter int ShiftValue    = 10,
  parameter int TimeoutCycles = 255
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                ScanEnable,
  input  logic [Channels-1:0] ChannelMask,
  output logic                SampleReq,
  output logic [ChBits-1:0]   SampleCh,
  input  logic                SampleAck,
  input  logic [DataBits-1:0] SampleData,
  output logic                ResultValid,
  output logic [ChBits-1:0]   ResultCh,
  output logic [DataBits-1:0] FixedValue,
  output logic [2:0]          ErrorReturn,
  input  logic [Channels-1:0] ErrClear,
  output logic [Channels-1:0] StickyErr,
  output logic                Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CHECK = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t              state_q;
  logic [ChBits-1:0]   last_ch_q;
  logic [7:0]          tmo_q;
  logic [DataBits-1:0] raw_q;
  logic                req_q;
  logic [ChBits-1:0]   ch_q;
  logic                valid_q;
  logic [ChBits-1:0]   res_ch_q;
  logic [DataBits-1:0] fixed_q;
  logic [2:0]          err_q;
  logic                busy_q;
  logic [Channels-1:0] sticky_q;
  logic [Channels-1:0] sticky_d;
  logic [Channels-1:0] sticky_set;

  logic [ChBits-1:0]   grant_ch;
  logic [ChBits-1:0]   cand_ch;
  logic                grant_hit;
  logic [DataBits:0]   diff;
  logic                out_of_range;

  // Walk downward so the nearest set bit above last_ch_q is the last one written.
  always_comb begin
    grant_ch  = '0;
    grant_hit = 1'b0;
    cand_ch   = '0;
    for (int off = Channels; off >= 1; off--) begin
      cand_ch = ChBits'((int'(last_ch_q) + off) % Channels);
      if (ChannelMask[cand_ch]) begin
        grant_ch  = cand_ch;
        grant_hit = 1'b1;
      end
    end
  end

  assign diff         = {1'b0, raw_q} - (DataBits+1)'(ShiftValue);
  assign out_of_range = (raw_q > DataBits'(UpBound)) || (raw_q < DataBits'(DownBound));

  // A set landing in OUT overrides a same-cycle clear of that bit.
  always_comb begin
    sticky_set = '0;
    if (state_q == OUT && err_q != 3'b000) begin
      sticky_set[ch_q] = 1'b1;
    end
    sticky_d = (sticky_q & ~ErrClear) | sticky_set;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      last_ch_q <= ChBits'(Channels - 1);
      tmo_q     <= '0;
      raw_q     <= '0;
      req_q     <= 1'b0;
      ch_q      <= '0;
      valid_q   <= 1'b0;
      res_ch_q  <= '0;
      fixed_q   <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      sticky_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ScanEnable && grant_hit) begin
            ch_q    <= grant_ch;
            tmo_q   <= '0;
            err_q   <= '0;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (SampleAck) begin
            raw_q   <= SampleData;
            req_q   <= 1'b0;
            state_q <= CHECK;
          end else if (tmo_q == 8'(TimeoutCycles - 1)) begin
            err_q    <= 3'b100;
            fixed_q  <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b1;
            res_ch_q <= ch_q;
            state_q  <= OUT;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        CHECK: begin
          err_q    <= {1'b0, diff[DataBits], out_of_range};
          fixed_q  <= diff[DataBits] ? '0 : diff[DataBits-1:0];
          valid_q  <= 1'b1;
          res_ch_q <= ch_q;
          state_q  <= OUT;
        end
        OUT: begin
          last_ch_q <= ch_q;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SampleReq   = req_q;
  assign SampleCh    = ch_q;
  assign ResultValid = valid_q;
  assign ResultCh    = res_ch_q;
  assign FixedValue  = fixed_q;
  assign ErrorReturn = err_q;
  assign StickyErr   = sticky_q;
  assign Busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_scan_ctl.sv
`default_nettype none
// ============================================================================
// tb_sensor_scan_ctl : vector table, corner sequences and randomized runs
//                      against a transaction-level reference model.
// Revision: 1.0
// ============================================================================
module tb_sensor_scan_ctl;

  logic       Clk;
  logic       Reset;
  logic       ScanEnable;
  logic [3:0] ChannelMask;
  logic       SampleReq;
  logic [1:0] SampleCh;
  logic       SampleAck;
  logic [9:0] SampleData;
  logic       ResultValid;
  logic [1:0] ResultCh;
  logic [9:0] FixedValue;
  logic [2:0] ErrorReturn;
  logic [3:0] ErrClear;
  logic [3:0] StickyErr;
  logic       Busy;

  sensor_scan_ctl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ScanEnable (ScanEnable),
    .ChannelMask(ChannelMask),
    .SampleReq  (SampleReq),
    .SampleCh   (SampleCh),
    .SampleAck  (SampleAck),
    .SampleData (SampleData),
    .ResultValid(ResultValid),
    .ResultCh   (ResultCh),
    .FixedValue (FixedValue),
    .ErrorReturn(ErrorReturn),
    .ErrClear   (ErrClear),
    .StickyErr  (StickyErr),
    .Busy       (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] mask;
    logic [9:0] data;
    int         delay;
    int         ech;
    int         efx;
    int         eer;
  } vec_t;

  vec_t vt [19];
  int   edge_vals [11] = '{0, 9, 10, 11, 15, 16, 17, 999, 1000, 1001, 1023};

  int n_checks = 0;
  int n_pass   = 0;

  int         mlast;
  logic [3:0] msticky;
  logic [3:0] r_mask;
  logic [3:0] r_clr;
  int         r_data;
  int         r_delay;
  int         r_ech;
  int         cnt;
  int         seen;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: round-robin grant and arithmetic straight from the rules.
  function automatic int model_next(input int last, input logic [3:0] mask);
    for (int off = 1; off <= 4; off++) begin
      if (((mask >> ((last + off) % 4)) & 4'd1) != 4'd0) return (last + off) % 4;
    end
    return -1;
  endfunction

  function automatic int exp_fixed(input int d);
    return (d >= 10) ? d - 10 : 0;
  endfunction

  function automatic int exp_err(input int d);
    int e;
    e = 0;
    if (d < 10) e += 2;
    if (d > 1000 || d < 16) e += 1;
    return e;
  endfunction

  task automatic do_reset();
    Reset       = 1'b1;
    ScanEnable  = 1'b0;
    ChannelMask = 4'd0;
    SampleAck   = 1'b0;
    SampleData  = 10'd0;
    ErrClear    = 4'd0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Plays the sensor port for one request: ack after 'delay' REQ cycles.
  task automatic do_sample(input int delay, input logic [9:0] data, input bit drop,
                           output int rq_ch, output int rs_ch, output int fx,
                           output int er, output int lat);
    int n;
    int stable;
    n = 0;
    while (SampleReq !== 1'b1 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (SampleReq !== 1'b1) begin
      check("req_rise_timeout", 0, 1);
      rq_ch = -1; rs_ch = -1; fx = -1; er = -1; lat = -1;
      return;
    end
    rq_ch = int'(SampleCh);
    if (drop) ScanEnable = 1'b0;
    stable = 1;
    for (int k = 0; k < delay; k++) begin
      @(negedge Clk);
      if (SampleReq !== 1'b1 || int'(SampleCh) != rq_ch) stable = 0;
    end
    SampleAck  = 1'b1;
    SampleData = data;
    @(negedge Clk);
    SampleAck  = 1'b0;
    SampleData = 10'($urandom_range(0, 1023));
    check("req_stable", stable, 1);
    check("req_fall", int'(SampleReq), 0);
    lat = 1;
    while (ResultValid !== 1'b1 && lat < 8) begin
      @(negedge Clk);
      lat++;
    end
    rs_ch = int'(ResultCh);
    fx    = int'(FixedValue);
    er    = int'(ErrorReturn);
  endtask

  task automatic run_check(input string tag, input logic [3:0] mask, input logic [9:0] data,
                           input int delay, input bit drop,
                           input int ech, input int efx, input int eer);
    int rq_ch, rs_ch, fx, er, lat;
    ChannelMask = mask;
    do_sample(delay, data, drop, rq_ch, rs_ch, fx, er, lat);
    check({tag, ".req_ch"}, rq_ch, ech);
    check({tag, ".res_ch"}, rs_ch, ech);
    check({tag, ".fixed"}, fx, efx);
    check({tag, ".err"}, er, eer);
    check({tag, ".latency"}, lat, 2);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0]  = '{4'hF, 10'd500,  2, 0, 490,  0};
    vt[1]  = '{4'hF, 10'd500,  2, 1, 490,  0};
    vt[2]  = '{4'hF, 10'd500,  2, 2, 490,  0};
    vt[3]  = '{4'hF, 10'd500,  2, 3, 490,  0};
    vt[4]  = '{4'hF, 10'd500,  2, 0, 490,  0};
    vt[5]  = '{4'h5, 10'd200,  2, 2, 190,  0};
    vt[6]  = '{4'h5, 10'd200,  2, 0, 190,  0};
    vt[7]  = '{4'h5, 10'd200,  2, 2, 190,  0};
    vt[8]  = '{4'h5, 10'd200,  2, 0, 190,  0};
    vt[9]  = '{4'h2, 10'd5,    1, 1, 0,    3};
    vt[10] = '{4'hF, 10'd1020, 0, 2, 1010, 1};
    vt[11] = '{4'hF, 10'd1000, 0, 3, 990,  0};
    vt[12] = '{4'hF, 10'd16,   3, 0, 6,    0};
    vt[13] = '{4'hF, 10'd15,   1, 1, 5,    1};
    vt[14] = '{4'hF, 10'd10,   0, 2, 0,    1};
    vt[15] = '{4'hF, 10'd9,    0, 3, 0,    3};
    vt[16] = '{4'h8, 10'd1001, 0, 3, 991,  1};
    vt[17] = '{4'h1, 10'd0,    4, 0, 0,    3};
    vt[18] = '{4'hF, 10'd1023, 0, 1, 1013, 1};

    Reset       = 1'b1;
    ScanEnable  = 1'b0;
    ChannelMask = 4'd0;
    SampleAck   = 1'b0;
    SampleData  = 10'd0;
    ErrClear    = 4'd0;
    @(negedge Clk);
    check("rst.SampleReq",   int'(SampleReq),   0);
    check("rst.SampleCh",    int'(SampleCh),    0);
    check("rst.ResultValid", int'(ResultValid), 0);
    check("rst.ResultCh",    int'(ResultCh),    0);
    check("rst.FixedValue",  int'(FixedValue),  0);
    check("rst.ErrorReturn", int'(ErrorReturn), 0);
    check("rst.StickyErr",   int'(StickyErr),   0);
    check("rst.Busy",        int'(Busy),        0);

    // Vector table
    do_reset();
    ScanEnable = 1'b1;
    for (int i = 0; i < 19; i++) begin
      run_check($sformatf("vec%0d", i), vt[i].mask, vt[i].data, vt[i].delay, 1'b0,
                vt[i].ech, vt[i].efx, vt[i].eer);
    end
    @(negedge Clk);
    check("vec.sticky_all", int'(StickyErr), 15);

    // Same-cycle set/clear, then mid-scan disable
    do_reset();
    ScanEnable = 1'b1;
    run_check("stk", 4'h2, 10'd5, 1, 1'b1, 1, 0, 3);
    ErrClear = 4'b0010;
    @(negedge Clk);
    ErrClear = 4'b0000;
    check("stk.set_wins", int'(StickyErr), 2);
    seen = 0;
    repeat (10) begin
      @(negedge Clk);
      if (SampleReq === 1'b1) seen = 1;
    end
    check("drop.no_new_req", seen, 0);
    check("drop.busy_low", int'(Busy), 0);
    check("stk.err_held", int'(ErrorReturn), 3);
    ErrClear = 4'b0010;
    @(negedge Clk);
    ErrClear = 4'b0000;
    check("stk.cleared", int'(StickyErr), 0);

    // Ack timeout, then ack on the last permitted cycle
    do_reset();
    ScanEnable  = 1'b1;
    ChannelMask = 4'h1;
    cnt = 0;
    while (SampleReq !== 1'b1 && cnt < 50) begin
      @(negedge Clk);
      cnt++;
    end
    cnt = 0;
    while (SampleReq === 1'b1 && cnt < 400) begin
      cnt++;
      @(negedge Clk);
    end
    check("tmo.req_cycles", cnt, 255);
    check("tmo.valid", int'(ResultValid), 1);
    check("tmo.ch", int'(ResultCh), 0);
    check("tmo.err", int'(ErrorReturn), 4);
    check("tmo.fixed", int'(FixedValue), 0);
    @(negedge Clk);
    check("tmo.sticky", int'(StickyErr), 1);
    run_check("ack255", 4'h1, 10'd700, 254, 1'b0, 0, 690, 0);

    // Asynchronous reset while requesting channel 2
    do_reset();
    ScanEnable = 1'b1;
    run_check("rr.a", 4'hF, 10'd300, 0, 1'b0, 0, 290, 0);
    run_check("rr.b", 4'hF, 10'd300, 0, 1'b0, 1, 290, 0);
    cnt = 0;
    while (SampleReq !== 1'b1 && cnt < 50) begin
      @(negedge Clk);
      cnt++;
    end
    check("rr.req_ch2", int'(SampleCh), 2);
    #2 Reset = 1'b1;
    #1 check("rr.req_drop", int'(SampleReq), 0);
    seen = 0;
    repeat (3) begin
      @(negedge Clk);
      if (ResultValid === 1'b1) seen = 1;
    end
    Reset = 1'b0;
    check("rr.no_result", seen, 0);
    run_check("rr.restart", 4'hF, 10'd400, 0, 1'b0, 0, 390, 0);

    // Randomized runs against the reference model
    do_reset();
    ScanEnable = 1'b1;
    mlast   = 3;
    msticky = 4'd0;
    for (int it = 0; it < 40; it++) begin
      r_mask  = 4'($urandom_range(1, 15));
      r_delay = $urandom_range(0, 6);
      if ($urandom_range(0, 1) == 0) r_data = edge_vals[$urandom_range(0, 10)];
      else r_data = $urandom_range(0, 1023);
      if (it > 0) begin
        @(negedge Clk);
        check("rnd.sticky", int'(StickyErr), int'(msticky));
        r_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        ErrClear    = r_clr;
        ChannelMask = r_mask;
        @(negedge Clk);
        ErrClear = 4'd0;
        msticky  = msticky & ~r_clr;
      end
      r_ech = model_next(mlast, r_mask);
      run_check($sformatf("rnd%0d", it), r_mask, 10'(r_data), r_delay, 1'b0,
                r_ech, exp_fixed(r_data), exp_err(r_data));
      mlast = r_ech;
      if (exp_err(r_data) != 0) msticky = msticky | (4'd1 << r_ech);
    end
    @(negedge Clk);
    check("rnd.sticky_final", int'(StickyErr), int'(msticky));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
